shift_arbiter: RTL and testbench

Shares one combinational logical-shift-right datapath (the team's `LSR` module) among `NUM_REQ` requesters. Each requester presents an operand and shift amount with a valid/ready handshake. A round-robin arbiter picks one request per cycle and shifts its operand through `LSR`. The result lands in a single registered output stage tagged with the requester's index. Sits between the execution issue logic and any unit needing a logical right shift, so only one barrel shifter is instantiated.

---
 rtl/shift_pkg.sv | 9 +
 rtl/LSR.sv | 16 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/shift_arbiter.sv | 103 ++++++++++
 tb/tb_shift_arbiter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for shift-datapath sharing units.
package shift_pkg;

   // Bits needed to express a shift amount for a given operand width.
   function automatic int SHAMT_W(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/LSR.sv
// Combinational logical shift right, zero fill.
module LSR #(
   parameter int WIDTH   = 64,
   parameter int SHAMT_W = 6
) (
   input  logic [WIDTH-1:0]   data,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   result
);

   // Barrel shift; synthesis maps this onto log2(WIDTH) mux levels.
   always_comb begin
      result = data >> shamt;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   input  logic                 en,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(N);

   logic [IDX_W:0]   base_s;
   logic [IDX_W:0]   sum_s;
   logic [IDX_W:0]   cand_s;
   logic [IDX_W-1:0] idx_s;
   logic             hit_s;
   logic             found_s;

   // Scan ptr, ptr+1, ... modulo N; an out-of-range pointer restarts at 0.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found_s   = 1'b0;
      hit_s     = 1'b0;
      sum_s     = '0;
      cand_s    = '0;
      idx_s     = '0;
      base_s    = ({1'b0, ptr} < (IDX_W+1)'(N)) ? {1'b0, ptr} : '0;
      for (int k = 0; k < N; k++) begin
         sum_s  = base_s + (IDX_W+1)'(k);
         cand_s = (sum_s >= (IDX_W+1)'(N)) ? (sum_s - (IDX_W+1)'(N)) : sum_s;
         idx_s  = cand_s[IDX_W-1:0];
         hit_s  = en & ~found_s & req[idx_s];
         grant[idx_s] = grant[idx_s] | hit_s;
         grant_idx    = hit_s ? idx_s : grant_idx;
         found_s      = found_s | hit_s;
      end
   end

endmodule

// File: rtl/shift_arbiter.sv
// Shares a single logical-shift-right datapath among NUM_REQ requesters
// through a round-robin arbiter and one registered, id-tagged output stage.
module shift_arbiter
   import shift_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int NUM_REQ = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_REQ-1:0]                 req_valid,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]           req_data,
   input  logic [NUM_REQ*$clog2(WIDTH)-1:0]   req_shamt,
   output logic                               resp_valid,
   input  logic                               resp_ready,
   output logic [WIDTH-1:0]                   resp_data,
   output logic [$clog2(NUM_REQ)-1:0]         resp_id
);

   localparam int SW    = SHAMT_W(WIDTH);
   localparam int IDX_W = $clog2(NUM_REQ);

   // Request bundle sized for this instance.
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SW-1:0]    shamt;
   } req_t;

   req_t             req_arr_s [NUM_REQ];
   req_t             sel_req_s;
   logic [NUM_REQ-1:0] grant_s;
   logic [IDX_W-1:0] grant_idx_s;
   logic [IDX_W-1:0] next_ptr_s;
   logic [IDX_W-1:0] rr_ptr_r;
   logic [WIDTH-1:0] shift_res_s;
   logic             can_accept_s;
   logic             arb_en_s;
   logic             transfer_s;
   logic             resp_valid_r;
   logic [WIDTH-1:0] resp_data_r;
   logic [IDX_W-1:0] resp_id_r;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_arr_s[g] = '{data:  req_data[g*WIDTH +: WIDTH],
                              shamt: req_shamt[g*SW +: SW]};
   end

   // Output slot is free when empty or being drained; never grant during reset.
   always_comb begin
      can_accept_s = ~resp_valid_r | resp_ready;
      arb_en_s     = can_accept_s & ~reset;
      transfer_s   = |grant_s;
      req_ready    = grant_s;
   end

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_r),
      .en        (arb_en_s),
      .grant     (grant_s),
      .grant_idx (grant_idx_s)
   );

   assign sel_req_s = req_arr_s[grant_idx_s];

   LSR #(.WIDTH(WIDTH), .SHAMT_W(SW)) u_lsr (
      .data   (sel_req_s.data),
      .shamt  (sel_req_s.shamt),
      .result (shift_res_s)
   );

   // Pointer moves past the winner, wrapping at NUM_REQ-1 (not 2^IDX_W-1).
   always_comb begin
      if (grant_idx_s == IDX_W'(NUM_REQ - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = grant_idx_s + IDX_W'(1);
      end
   end

   // Output register and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid_r <= 1'b0;
         resp_data_r  <= '0;
         resp_id_r    <= '0;
         rr_ptr_r     <= '0;
      end else if (transfer_s) begin
         resp_valid_r <= 1'b1;
         resp_data_r  <= shift_res_s;
         resp_id_r    <= grant_idx_s;
         rr_ptr_r     <= next_ptr_s;
      end else if (resp_ready) begin
         resp_valid_r <= 1'b0;
      end
   end

   assign resp_valid = resp_valid_r;
   assign resp_data  = resp_data_r;
   assign resp_id    = resp_id_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter at WIDTH=16, NUM_REQ=4.
module tb_shift_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_data;
   logic [15:0] req_shamt;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_data;
   logic [1:0]  resp_id;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  id;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   shift_arbiter #(.WIDTH(16), .NUM_REQ(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .req_shamt  (req_shamt),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] oh_idx(input logic [3:0] oh);
      case (oh)
         4'b0001: return 2'd0;
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   task automatic set_req(input int i, input logic [15:0] d, input logic [3:0] s);
      req_data[i*16 +: 16] = d;
      req_shamt[i*4 +: 4]  = s;
   endtask

   // One cycle: drive, check the grant, record the expected result.
   task automatic drive(input logic [3:0] v, input logic r, input logic [3:0] exp_rdy,
                        input logic [15:0] exp_d);
      req_valid  = v;
      resp_ready = r;
      @(negedge clk);
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (exp_rdy != 4'b0000) begin
         sb_q.push_back('{data: exp_d, id: oh_idx(exp_rdy)});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb_q.delete();
      @(negedge clk);
      check("reset_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
      check("rst_valid", 32'(resp_valid), 32'h0);
      check("rst_data", 32'(resp_data), 32'h0);
      check("rst_id", 32'(resp_id), 32'h0);
      reset = 1'b0;
   endtask

   // Monitor: compare each result as it is handed off downstream.
   always @(negedge clk) begin
      if (!reset && resp_valid && resp_ready) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp: got data %0h id %0d, none expected", resp_data, resp_id);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("resp_data", 32'(resp_data), 32'(e.data));
            check("resp_id", 32'(resp_id), 32'(e.id));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] pat;
      reset      = 1'b1;
      req_valid  = 4'b1111;
      resp_ready = 1'b1;
      req_data   = '0;
      req_shamt  = '0;
      @(posedge clk);
      #1;
      do_reset();

      // Idle after reset
      for (int i = 0; i < 3; i++) begin
         drive(4'b0000, 1'b1, 4'b0000, 16'h0);
         check("idle_valid", 32'(resp_valid), 32'h0);
         check("idle_data", 32'(resp_data), 32'h0);
         check("idle_id", 32'(resp_id), 32'h0);
      end

      // Single request and shift-amount sweep
      set_req(2, 16'hF000, 4'd4);
      drive(4'b0100, 1'b1, 4'b0100, 16'h0F00);
      pat = 16'hA5C3;
      for (int s = 0; s < 16; s++) begin
         set_req(2, pat, 4'(s));
         drive(4'b0100, 1'b1, 4'b0100, pat >> s);
      end
      drive(4'b0000, 1'b1, 4'b0000, 16'h0);

      // Fairness from pointer 0
      do_reset();
      set_req(0, 16'h1234, 4'd0);
      set_req(1, 16'h8000, 4'd1);
      set_req(2, 16'hFFFF, 4'd8);
      set_req(3, 16'h0F0F, 4'd4);
      for (int r = 0; r < 2; r++) begin
         drive(4'b1111, 1'b1, 4'b0001, 16'h1234);
         drive(4'b1111, 1'b1, 4'b0010, 16'h4000);
         drive(4'b1111, 1'b1, 4'b0100, 16'h00FF);
         drive(4'b1111, 1'b1, 4'b1000, 16'h00F0);
      end
      drive(4'b0000, 1'b1, 4'b0000, 16'h0);
      check("drain_valid", 32'(resp_valid), 32'h0);
      check("drain_data_hold", 32'(resp_data), 32'h00F0);
      check("drain_id_hold", 32'(resp_id), 32'h3);

      // Backpressure: hold for 3 cycles, then drain and accept together
      drive(4'b1111, 1'b1, 4'b0001, 16'h1234);
      for (int i = 0; i < 3; i++) begin
         drive(4'b1111, 1'b0, 4'b0000, 16'h0);
         check("stall_valid", 32'(resp_valid), 32'h1);
         check("stall_data", 32'(resp_data), 32'h1234);
         check("stall_id", 32'(resp_id), 32'h0);
      end
      drive(4'b1111, 1'b1, 4'b0010, 16'h4000);
      check("no_bubble_valid", 32'(resp_valid), 32'h1);
      drive(4'b0000, 1'b1, 4'b0000, 16'h0);

      // Sparse requests with pointer at 2
      set_req(1, 16'h00F0, 4'd4);
      set_req(3, 16'hC000, 4'd14);
      drive(4'b1010, 1'b1, 4'b1000, 16'h0003);
      drive(4'b1010, 1'b1, 4'b0010, 16'h000F);
      drive(4'b1010, 1'b1, 4'b1000, 16'h0003);
      drive(4'b0000, 1'b1, 4'b0000, 16'h0);

      // Reset while a result is stalled
      drive(4'b0110, 1'b1, 4'b0010, 16'h000F);
      drive(4'b0110, 1'b0, 4'b0000, 16'h0);
      check("held_valid", 32'(resp_valid), 32'h1);
      req_valid = 4'b0110;
      do_reset();
      drive(4'b0110, 1'b1, 4'b0010, 16'h000F);
      drive(4'b0000, 1'b1, 4'b0000, 16'h0);

      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
